// File: rtl/opidivctl_pkg.sv
// Shared definitions for the divider request/result path: widths, packing offsets
// and the zero-divisor result that the opidiv pool also produces.
package opidivctl_pkg;

  localparam int ARCHBITSZ     = 16;
  localparam int GPRCNT        = 32;
  localparam int CLOG2GPRCNT   = $clog2(GPRCNT);
  localparam int IDIVTYPEBITSZ = 2;
  localparam int DIVREQBITSZ   = 2*ARCHBITSZ + CLOG2GPRCNT + IDIVTYPEBITSZ;

  // Request packing, LSB offsets: {signed, rem, gprid, lval, rval}
  localparam int IDIVRVAL    = 0;
  localparam int IDIVLVAL    = ARCHBITSZ;
  localparam int IDIVGPRID   = 2*ARCHBITSZ;
  localparam int IDIVMSBRSLT = 2*ARCHBITSZ + CLOG2GPRCNT;
  localparam int IDIVSIGNED  = IDIVMSBRSLT + 1;

  function automatic logic [ARCHBITSZ-1:0] divzero_result(
    input logic                 sgn,
    input logic                 rem,
    input logic [ARCHBITSZ-1:0] lval
  );
    logic [ARCHBITSZ-1:0] res;
    if (rem)
      res = lval;
    else if (sgn && lval[ARCHBITSZ-1])
      res = ARCHBITSZ'(1);
    else
      res = '1;
    return res;
  endfunction

endpackage

// File: rtl/opidivctl_gprsb.sv
// GPR busy scoreboard: one bit per GPR, a set port, a clear port and two
// combinational lookup ports. The full vector is exported for the issue check.
module opidivctl_gprsb
  import opidivctl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   set_en_i,
  input  logic [CLOG2GPRCNT-1:0] set_id_i,
  input  logic                   clr_en_i,
  input  logic [CLOG2GPRCNT-1:0] clr_id_i,
  input  logic [CLOG2GPRCNT-1:0] lka_id_i,
  input  logic [CLOG2GPRCNT-1:0] lkb_id_i,
  output logic                   lka_busy_o,
  output logic                   lkb_busy_o,
  output logic [GPRCNT-1:0]      busy_o
);

  logic [GPRCNT-1:0] busy_q;
  logic [GPRCNT-1:0] busy_d;

  for (genvar gi = 0; gi < GPRCNT; gi++) begin : g_bit
    always_comb begin
      busy_d[gi] = busy_q[gi];
      if (clr_en_i && (clr_id_i == CLOG2GPRCNT'(gi)))
        busy_d[gi] = 1'b0;
      if (set_en_i && (set_id_i == CLOG2GPRCNT'(gi)))
        busy_d[gi] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign lka_busy_o = busy_q[lka_id_i];
  assign lkb_busy_o = busy_q[lkb_id_i];
  assign busy_o     = busy_q;

endmodule

// File: rtl/opidivctl.sv
// Divider issue/writeback controller. Define PUIDIVCTL_DIVZERO_EN to resolve
// zero-divisor requests locally through a one-entry bypass register.
module opidivctl
  import opidivctl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_stb_i,
  output logic                   req_rdy_o,
  input  logic                   req_signed_i,
  input  logic                   req_rem_i,
  input  logic [CLOG2GPRCNT-1:0] req_gprid_i,
  input  logic [ARCHBITSZ-1:0]   req_lval_i,
  input  logic [ARCHBITSZ-1:0]   req_rval_i,
  output logic                   div_stb_o,
  output logic [DIVREQBITSZ-1:0] div_data_o,
  input  logic                   div_rdy_i,
  input  logic                   div_ordy_i,
  input  logic [ARCHBITSZ-1:0]   div_data_i,
  input  logic [CLOG2GPRCNT-1:0] div_gprid_i,
  output logic                   div_ostb_o,
  output logic                   gpr_we_o,
  output logic [CLOG2GPRCNT-1:0] gpr_id_o,
  output logic [ARCHBITSZ-1:0]   gpr_data_o,
  input  logic                   gpr_gnt_i,
  input  logic [CLOG2GPRCNT-1:0] chk_a_i,
  input  logic [CLOG2GPRCNT-1:0] chk_b_i,
  output logic                   busy_a_o,
  output logic                   busy_b_o,
  output logic                   idle_o
);

  logic                   bypass_sel;
  logic                   byp_full;
  logic [CLOG2GPRCNT-1:0] byp_id;
  logic [ARCHBITSZ-1:0]   byp_data;
  logic [GPRCNT-1:0]      busy_vec;
  logic                   lka_busy, lkb_busy;
  logic                   path_rdy, accept, wb_hs, sel_div;

  assign path_rdy  = bypass_sel ? !byp_full : div_rdy_i;
  assign req_rdy_o = !busy_vec[req_gprid_i] && path_rdy;
  assign accept    = req_stb_i && req_rdy_o;
  assign div_stb_o = accept && !bypass_sel;

  assign div_data_o[IDIVSIGNED]                  = req_signed_i;
  assign div_data_o[IDIVMSBRSLT]                 = req_rem_i;
  assign div_data_o[IDIVGPRID +: CLOG2GPRCNT]    = req_gprid_i;
  assign div_data_o[IDIVLVAL +: ARCHBITSZ]       = req_lval_i;
  assign div_data_o[IDIVRVAL +: ARCHBITSZ]       = req_rval_i;

  // A divider result always wins, so the bypass entry waits behind it.
  assign sel_div    = div_ordy_i;
  assign gpr_we_o   = div_ordy_i || byp_full;
  assign gpr_id_o   = sel_div ? div_gprid_i : byp_id;
  assign gpr_data_o = sel_div ? div_data_i : byp_data;
  assign wb_hs      = gpr_we_o && gpr_gnt_i;
  assign div_ostb_o = wb_hs && sel_div;

`ifdef PUIDIVCTL_DIVZERO_EN
  logic                   byp_full_q, byp_full_d;
  logic [CLOG2GPRCNT-1:0] byp_id_q, byp_id_d;
  logic [ARCHBITSZ-1:0]   byp_data_q, byp_data_d;

  assign bypass_sel = (req_rval_i == '0);

  // Fill and drain are exclusive: filling requires the entry to be empty.
  always_comb begin
    byp_full_d = byp_full_q;
    byp_id_d   = byp_id_q;
    byp_data_d = byp_data_q;
    if (wb_hs && !sel_div)
      byp_full_d = 1'b0;
    if (accept && bypass_sel) begin
      byp_full_d = 1'b1;
      byp_id_d   = req_gprid_i;
      byp_data_d = divzero_result(req_signed_i, req_rem_i, req_lval_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byp_full_q <= 1'b0;
      byp_id_q   <= '0;
      byp_data_q <= '0;
    end else begin
      byp_full_q <= byp_full_d;
      byp_id_q   <= byp_id_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign byp_full = byp_full_q;
  assign byp_id   = byp_id_q;
  assign byp_data = byp_data_q;
`else
  assign bypass_sel = 1'b0;
  assign byp_full   = 1'b0;
  assign byp_id     = '0;
  assign byp_data   = '0;
`endif

  opidivctl_gprsb u_gprsb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (accept),
    .set_id_i   (req_gprid_i),
    .clr_en_i   (wb_hs),
    .clr_id_i   (gpr_id_o),
    .lka_id_i   (chk_a_i),
    .lkb_id_i   (chk_b_i),
    .lka_busy_o (lka_busy),
    .lkb_busy_o (lkb_busy),
    .busy_o     (busy_vec)
  );

  // Forward the acceptance-cycle destination so hazards are seen immediately.
  assign busy_a_o = lka_busy || (accept && (req_gprid_i == chk_a_i));
  assign busy_b_o = lkb_busy || (accept && (req_gprid_i == chk_b_i));
  assign idle_o   = (busy_vec == '0) && !byp_full;

endmodule

// File: tb/tb_opidivctl.sv
// Table-driven bench for opidivctl; the bench plays the divider pool and the
// writeback arbiter, with hand-computed expected results.
module tb_opidivctl;
  import opidivctl_pkg::*;

  localparam int AW = ARCHBITSZ;
  localparam int CW = CLOG2GPRCNT;
  localparam int DW = DIVREQBITSZ;
`ifdef PUIDIVCTL_DIVZERO_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic          clk_i, rst_i;
  logic          req_stb_i, req_rdy_o, req_signed_i, req_rem_i;
  logic [CW-1:0] req_gprid_i;
  logic [AW-1:0] req_lval_i, req_rval_i;
  logic          div_stb_o, div_rdy_i, div_ordy_i, div_ostb_o;
  logic [DW-1:0] div_data_o;
  logic [AW-1:0] div_data_i;
  logic [CW-1:0] div_gprid_i;
  logic          gpr_we_o, gpr_gnt_i;
  logic [CW-1:0] gpr_id_o;
  logic [AW-1:0] gpr_data_o;
  logic [CW-1:0] chk_a_i, chk_b_i;
  logic          busy_a_o, busy_b_o, idle_o;

  opidivctl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_stb_i(req_stb_i), .req_rdy_o(req_rdy_o), .req_signed_i(req_signed_i),
    .req_rem_i(req_rem_i), .req_gprid_i(req_gprid_i), .req_lval_i(req_lval_i),
    .req_rval_i(req_rval_i), .div_stb_o(div_stb_o), .div_data_o(div_data_o),
    .div_rdy_i(div_rdy_i), .div_ordy_i(div_ordy_i), .div_data_i(div_data_i),
    .div_gprid_i(div_gprid_i), .div_ostb_o(div_ostb_o), .gpr_we_o(gpr_we_o),
    .gpr_id_o(gpr_id_o), .gpr_data_o(gpr_data_o), .gpr_gnt_i(gpr_gnt_i),
    .chk_a_i(chk_a_i), .chk_b_i(chk_b_i), .busy_a_o(busy_a_o),
    .busy_b_o(busy_b_o), .idle_o(idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          sgn;
    logic          rem;
    logic [CW-1:0] gprid;
    logic [AW-1:0] lval;
    logic [AW-1:0] rval;
    logic [AW-1:0] exp_data;
  } vec_t;

  vec_t vecs [11];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic s, input logic r, input int id,
                              input logic [AW-1:0] l, input logic [AW-1:0] rv,
                              input logic [AW-1:0] e);
    vec_t v;
    v.sgn = s; v.rem = r; v.gprid = CW'(id); v.lval = l; v.rval = rv; v.exp_data = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behaviour of the divider pool for a packed request.
  function automatic logic [AW-1:0] model_div(input logic [DW-1:0] pkt);
    logic                 s, r;
    logic [AW-1:0]        l, d, res;
    logic signed [AW-1:0] sl, sd;
    s = pkt[DW-1]; r = pkt[DW-2];
    l = pkt[AW +: AW]; d = pkt[0 +: AW];
    sl = l; sd = d;
    if (d == '0)
      res = r ? l : ((s && l[AW-1]) ? AW'(1) : '1);
    else if (s)
      res = r ? AW'(sl % sd) : AW'(sl / sd);
    else
      res = r ? (l % d) : (l / d);
    return res;
  endfunction

  task automatic drive_req(input logic s, input logic r, input logic [CW-1:0] id,
                           input logic [AW-1:0] l, input logic [AW-1:0] rv);
    req_stb_i = 1'b1; req_signed_i = s; req_rem_i = r;
    req_gprid_i = id; req_lval_i = l; req_rval_i = rv;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic          byp;
    logic [DW-1:0] pkt;
    byp = BYPASS_EN && (v.rval == '0);
    @(posedge clk_i); #1;
    drive_req(v.sgn, v.rem, v.gprid, v.lval, v.rval);
    chk_a_i = v.gprid; chk_b_i = v.gprid ^ CW'(1);
    @(negedge clk_i);
    chk("req_rdy", 64'(req_rdy_o), 64'(1));
    chk("div_stb", 64'(div_stb_o), 64'(!byp));
    if (!byp) chk("div_data", 64'(div_data_o), 64'({v.sgn, v.rem, v.gprid, v.lval, v.rval}));
    chk("busy_a_fwd", 64'(busy_a_o), 64'(1));
    chk("busy_b_other", 64'(busy_b_o), 64'(0));
    pkt = div_data_o;
    @(posedge clk_i); #1;
    req_stb_i = 1'b0;
    if (!byp) begin
      div_ordy_i = 1'b1; div_data_i = model_div(pkt); div_gprid_i = pkt[2*AW +: CW];
    end
    gpr_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("gpr_we", 64'(gpr_we_o), 64'(1));
    chk("gpr_id", 64'(gpr_id_o), 64'(v.gprid));
    chk("gpr_data", 64'(gpr_data_o), 64'(v.exp_data));
    chk("div_ostb", 64'(div_ostb_o), 64'(!byp));
    chk("busy_a_reg", 64'(busy_a_o), 64'(1));
    chk("idle_busy", 64'(idle_o), 64'(0));
    @(posedge clk_i); #1;
    div_ordy_i = 1'b0; gpr_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("gpr_we_done", 64'(gpr_we_o), 64'(0));
    chk("busy_a_clr", 64'(busy_a_o), 64'(0));
    chk("idle_done", 64'(idle_o), 64'(1));
    $display("vec %0d: s=%0d r=%0d gpr=%0d 0x%h/0x%h -> 0x%h (%s)", idx, v.sgn, v.rem,
             v.gprid, v.lval, v.rval, gpr_data_o, byp ? "bypass" : "divider");
  endtask

  initial begin
    logic [DW-1:0] pkt;
    rst_i = 1'b0; req_stb_i = 1'b0; req_signed_i = 1'b0; req_rem_i = 1'b0;
    req_gprid_i = '0; req_lval_i = '0; req_rval_i = '0; div_rdy_i = 1'b1;
    div_ordy_i = 1'b0; div_data_i = '0; div_gprid_i = '0; gpr_gnt_i = 1'b0;
    chk_a_i = '0; chk_b_i = '0;

    vecs[0]  = mk(0, 0,  5, 16'd11,   16'd3,    16'h0003);
    vecs[1]  = mk(0, 1,  5, 16'd11,   16'd3,    16'h0002);
    vecs[2]  = mk(1, 0,  1, 16'hFFAB, 16'd7,    16'hFFF4);
    vecs[3]  = mk(1, 1,  2, 16'hFFAB, 16'd7,    16'hFFFF);
    vecs[4]  = mk(1, 0,  3, 16'h0055, 16'hFFF9, 16'hFFF4);
    vecs[5]  = mk(1, 1,  4, 16'h0055, 16'hFFF9, 16'h0001);
    vecs[6]  = mk(0, 0,  6, 16'h1234, 16'h0000, 16'hFFFF);
    vecs[7]  = mk(1, 0,  8, 16'h8000, 16'h0000, 16'h0001);
    vecs[8]  = mk(1, 1,  9, 16'h8000, 16'h0000, 16'h8000);
    vecs[9]  = mk(0, 0, 31, 16'hFFFF, 16'h0001, 16'hFFFF);
    vecs[10] = mk(0, 1,  0, 16'h0064, 16'h00C8, 16'h0064);

    #3;
    chk("rst_req_rdy", 64'(req_rdy_o), 64'(1));
    chk("rst_div_stb", 64'(div_stb_o), 64'(0));
    chk("rst_div_ostb", 64'(div_ostb_o), 64'(0));
    chk("rst_gpr_we", 64'(gpr_we_o), 64'(0));
    chk("rst_busy_a", 64'(busy_a_o), 64'(0));
    chk("rst_busy_b", 64'(busy_b_o), 64'(0));
    chk("rst_idle", 64'(idle_o), 64'(1));
    #9 rst_i = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Same-destination hazard: second request to GPR 7 waits for the grant.
    @(posedge clk_i); #1;
    drive_req(0, 0, 5'd7, 16'd20, 16'd4); chk_a_i = 5'd7;
    @(negedge clk_i);
    chk("haz_first_rdy", 64'(req_rdy_o), 64'(1));
    pkt = div_data_o;
    @(posedge clk_i); #1;
    drive_req(0, 1, 5'd7, 16'd21, 16'd4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("haz_rdy_low", 64'(req_rdy_o), 64'(0));
      chk("haz_busy_a", 64'(busy_a_o), 64'(1));
      chk("haz_no_stb", 64'(div_stb_o), 64'(0));
      @(posedge clk_i); #1;
    end
    div_ordy_i = 1'b1; div_data_i = model_div(pkt); div_gprid_i = pkt[2*AW +: CW];
    gpr_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("haz_rdy_at_gnt", 64'(req_rdy_o), 64'(0));
    chk("haz_wb_data", 64'(gpr_data_o), 64'(16'd5));
    chk("haz_ostb", 64'(div_ostb_o), 64'(1));
    @(posedge clk_i); #1;
    div_ordy_i = 1'b0; gpr_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("haz_rdy_after", 64'(req_rdy_o), 64'(1));
    chk("haz_stb_after", 64'(div_stb_o), 64'(1));
    pkt = div_data_o;
    @(posedge clk_i); #1;
    req_stb_i = 1'b0;
    div_ordy_i = 1'b1; div_data_i = model_div(pkt); div_gprid_i = pkt[2*AW +: CW];
    gpr_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("haz_second_data", 64'(gpr_data_o), 64'(16'd1));
    @(posedge clk_i); #1;
    div_ordy_i = 1'b0; gpr_gnt_i = 1'b0;
    $display("hazard seq: GPR 7 reissued after writeback grant");

    // Grant stall: result must hold for 10 cycles, then pop exactly once.
    @(posedge clk_i); #1;
    drive_req(0, 0, 5'd10, 16'd11, 16'd3);
    @(negedge clk_i);
    pkt = div_data_o;
    @(posedge clk_i); #1;
    req_stb_i = 1'b0;
    div_ordy_i = 1'b1; div_data_i = model_div(pkt); div_gprid_i = pkt[2*AW +: CW];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      chk("stall_we", 64'(gpr_we_o), 64'(1));
      chk("stall_id", 64'(gpr_id_o), 64'(10));
      chk("stall_data", 64'(gpr_data_o), 64'(3));
      chk("stall_ostb", 64'(div_ostb_o), 64'(0));
    end
    @(posedge clk_i); #1;
    gpr_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("stall_pop", 64'(div_ostb_o), 64'(1));
    @(posedge clk_i); #1;
    div_ordy_i = 1'b0; gpr_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("stall_single_pop", 64'(div_ostb_o), 64'(0));
    chk("stall_we_done", 64'(gpr_we_o), 64'(0));
    chk("stall_idle", 64'(idle_o), 64'(1));
    $display("stall seq: 10 stalled cycles then one pop");

    // Asynchronous reset with a division pending.
    @(posedge clk_i); #1;
    drive_req(0, 0, 5'd12, 16'h1234, 16'h0000); chk_a_i = 5'd12; chk_b_i = 5'd12;
    @(posedge clk_i); #1;
    req_stb_i = 1'b0;
    @(negedge clk_i);
    chk("prerst_busy_a", 64'(busy_a_o), 64'(1));
    chk("prerst_idle", 64'(idle_o), 64'(0));
    chk("prerst_we", 64'(gpr_we_o), 64'(BYPASS_EN));
    #2 rst_i = 1'b0;
    #1;
    chk("arst_busy_a", 64'(busy_a_o), 64'(0));
    chk("arst_busy_b", 64'(busy_b_o), 64'(0));
    chk("arst_idle", 64'(idle_o), 64'(1));
    chk("arst_we", 64'(gpr_we_o), 64'(0));
    #4 rst_i = 1'b1;
    $display("reset seq: pending GPR 12 discarded");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
